imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Single-port instruction-memory controller for the MIPS core. It shares the 256-word instruction memory between the CPU fetch path and a program loader (host/debug port), and holds the CPU while a program is loaded. It performs one memory access per cycle, returns read data registered one cycle later, and rejects misaligned or out-of-range addresses. It sits between the fetch stage, the loader, and the combinational-read/synchronous-write memory array.

## Interface
- ADDR_W, 8, word-address width (memory depth 2^ADDR_W words)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  CPU requests an instruction read
- fetch_addr  in  32  byte address from the PC
- fetch_gnt  out  1  fetch access performed this cycle (combinational)
- fetch_valid  out  1  fetch_data valid (one-cycle pulse)
- fetch_data  out  32  registered instruction
- fetch_err  out  1  qualifies fetch_valid: address was rejected
- load_req  in  1  loader requests an access
- load_we  in  1  1 = write, 0 = read
- load_addr  in  32  byte address
- load_wdata  in  32  write data
- load_gnt  out  1  loader access performed this cycle (combinational)
- load_valid  out  1  read data, or write acknowledge (one-cycle pulse)
- load_rdata  out  32  registered read data (0 for writes)
- load_err  out  1  qualifies load_valid: address was rejected
- prog_start  in  1  pulse: enter program-load mode
- prog_done  in  1  pulse: leave program-load mode
- cpu_hold  out  1  CPU must freeze its PC
- stall_cnt  out  16  saturating count of denied fetch cycles
- mem_addr  out  ADDR_W  word address to the memory array
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational memory read data

## Operation
- FSM states: BOOT (reset state), RUN, LOAD.
  - BOOT/LOAD: only the loader is served; fetch_gnt=0.
  - prog_done moves BOOT→RUN and LOAD→RUN.
  - prog_start in RUN moves RUN→LOAD.
  - prog_start is ignored in BOOT and LOAD. prog_start and prog_done together in BOOT/LOAD go to RUN.
- cpu_hold = (state != RUN). It is combinational from the state register.
- Arbitration in RUN:
  - Round-robin pointer rr (reset 0 = fetch preferred).
  - A single requester is granted.
  - If both request, the rr-preferred side is granted.
  - After any grant, rr points to the side that was not granted.
  - rr is unchanged in idle cycles.
- Address check for the granted requester:
  - Good: addr[1:0]==0 and addr[31:ADDR_W+2]==0.
  - Bad: the grant is still given, mem_we=0, and on the next cycle valid=1, err=1, data=0.
- Good address: mem_addr=addr[ADDR_W+1:2]. mem_we = load_gnt & load_we. mem_wdata = load_wdata.
- When no access occurs, mem_addr=0, mem_we=0 and mem_wdata=0.
- stall_cnt increments on each RUN cycle with fetch_req & !fetch_gnt and saturates at 16'hFFFF. It is not counted in BOOT/LOAD and is cleared only by reset.

## Timing
- Grant is combinational in the request cycle. The requester must hold req/addr/wdata stable until it sees gnt high.
- Read latency is one cycle: mem_rdata is captured at the grant-cycle edge. fetch_valid/load_valid are high for exactly the following cycle.
- Writes commit at the grant-cycle edge. load_valid pulses on the next cycle with load_rdata=0.
- A loader read immediately after a write to the same address returns the new value.
- A state change takes effect on the cycle after the prog_* edge. A fetch granted in the last RUN cycle still returns its fetch_valid in the first LOAD cycle.
- Reset values (asynchronous):
  - state=BOOT, cpu_hold=1, rr=0.
  - fetch_valid=0, fetch_data=0, fetch_err=0.
  - load_valid=0, load_rdata=0, load_err=0.
  - stall_cnt=0.
- Reset asserted mid-access drops any pending valid pulse. No write occurs in a cycle where reset is high.

## Test plan
- Boot load: reset, then the loader writes 0x20080005 to byte address 0x0 and 0x20090003 to 0x4 while fetch_req=1. Required: fetch_gnt=0 and cpu_hold=1 throughout. Then prog_done; the next cycle cpu_hold=0, and a fetch of 0x4 returns 0x20090003 with fetch_valid one cycle after the grant.
- Contention: in RUN, fetch and a loader read both request for 4 cycles. Required: grants alternate fetch, load, fetch, load, and stall_cnt=2.
- Misalignment/range: fetch 0x2 and fetch 0x400 (ADDR_W=8). Required: each gives fetch_valid=1, fetch_err=1, fetch_data=0, with no memory write.
- Reload: in RUN, prog_start, loader writes 0xDEADBEEF to 0x10, then prog_done. Required: cpu_hold high only between the two pulses, and a fetch of 0x10 returns 0xDEADBEEF.
- Saturation/reset: hold fetch_req while a loader flood keeps the fetch denied long enough for stall_cnt to reach 0xFFFF. Required: the counter sticks at 0xFFFF. Then assert reset mid-access: all outputs return to reset values asynchronously and state=BOOT.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if
//   Groups the instruction-memory controller's bus signals into one bundle.
//   The fetch path, the program loader, the mode-control pulses, the status
//   outputs and the memory-array port are all carried here.
//   Ports (slave = controller side, master = fetch stage, loader and memory side):
//     fetch_req/fetch_addr            -> fetch request, byte address
//     fetch_gnt/valid/data/err        <- fetch grant and registered response
//     load_req/we/addr/wdata          -> loader request
//     load_gnt/valid/rdata/err        <- loader grant and registered response
//     prog_start/prog_done            -> enter / leave program-load mode
//     cpu_hold, stall_cnt             <- CPU freeze and denied-fetch count
//     mem_addr/we/wdata               <- memory-array access
//     mem_rdata                       -> combinational memory read data
interface imem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [31:0]       fetch_data;
  logic              fetch_err;

  logic              load_req;
  logic              load_we;
  logic [31:0]       load_addr;
  logic [31:0]       load_wdata;
  logic              load_gnt;
  logic              load_valid;
  logic [31:0]       load_rdata;
  logic              load_err;

  logic              prog_start;
  logic              prog_done;
  logic              cpu_hold;
  logic [15:0]       stall_cnt;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_gnt, fetch_valid, fetch_data, fetch_err,
    input  load_req, load_we, load_addr, load_wdata,
    output load_gnt, load_valid, load_rdata, load_err,
    input  prog_start, prog_done,
    output cpu_hold, stall_cnt,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_gnt, fetch_valid, fetch_data, fetch_err,
    output load_req, load_we, load_addr, load_wdata,
    input  load_gnt, load_valid, load_rdata, load_err,
    output prog_start, prog_done,
    input  cpu_hold, stall_cnt,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Single-port instruction-memory controller. It shares a 2^ADDR_W-word
//   memory between the CPU fetch path and a program loader. It performs one
//   access per cycle, returns read data registered one cycle later, and
//   rejects misaligned or out-of-range byte addresses. While a program is
//   loaded (BOOT/LOAD) only the loader is served and the CPU is held.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-high reset
//     bus    - imem_arbiter_if.slave (fetch, loader, mode control, status,
//              memory-array port)
//   Parameters:
//     ADDR_W  - word-address width
//     STALL_W - width of the saturating stall counter (1..16); the
//               stall_cnt port is always 16 bits, zero-extended
module imem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int STALL_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  imem_arbiter_if.slave  bus
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic               rr_q;      // 0: fetch preferred, 1: loader preferred
  logic [STALL_W-1:0] stall_q;

  logic               run;
  logic               f_gnt;
  logic               l_gnt;
  logic               acc;
  logic [31:0]        acc_addr;
  logic               acc_ok;

  // A byte address is usable when word-aligned and inside the array.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:ADDR_W+2] == '0);
  endfunction

  assign run          = (state_q == RUN);
  assign bus.cpu_hold = !run;

  // Grant: in RUN the round-robin pointer breaks ties; outside RUN only the
  // loader may use the memory.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (run) begin
      if (bus.fetch_req && bus.load_req) begin
        f_gnt = !rr_q;
        l_gnt = rr_q;
      end else begin
        f_gnt = bus.fetch_req;
        l_gnt = bus.load_req;
      end
    end else begin
      l_gnt = bus.load_req;
    end
  end

  assign bus.fetch_gnt = f_gnt;
  assign bus.load_gnt  = l_gnt;

  assign acc      = f_gnt || l_gnt;
  assign acc_addr = f_gnt ? bus.fetch_addr : bus.load_addr;
  assign acc_ok   = addr_ok(acc_addr);

  // A rejected access still consumes the grant but never reaches the array.
  // The write enable is also masked by reset so nothing commits while the
  // controller is being reset.
  assign bus.mem_addr  = (acc && acc_ok) ? acc_addr[ADDR_W+1:2] : '0;
  assign bus.mem_wdata = (acc && acc_ok) ? bus.load_wdata : '0;
  assign bus.mem_we    = l_gnt && bus.load_we && acc_ok && !reset;

  // Mode FSM. prog_done wins over prog_start outside RUN; prog_done in RUN
  // and prog_start outside RUN are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT, LOAD: if (bus.prog_done)  state_d = RUN;
      RUN:        if (bus.prog_start) state_d = LOAD;
      default:    state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= BOOT;
      rr_q            <= 1'b0;
      stall_q         <= '0;
      bus.fetch_valid <= 1'b0;
      bus.fetch_err   <= 1'b0;
      bus.fetch_data  <= '0;
      bus.load_valid  <= 1'b0;
      bus.load_err    <= 1'b0;
      bus.load_rdata  <= '0;
    end else begin
      state_q <= state_d;

      // Point at the side that lost (or did not ask); idle cycles keep rr.
      if (run && acc) rr_q <= f_gnt;

      bus.fetch_valid <= f_gnt;
      bus.fetch_err   <= f_gnt && !acc_ok;
      if (f_gnt) bus.fetch_data <= acc_ok ? bus.mem_rdata : '0;

      bus.load_valid <= l_gnt;
      bus.load_err   <= l_gnt && !acc_ok;
      if (l_gnt) bus.load_rdata <= (acc_ok && !bus.load_we) ? bus.mem_rdata : '0;

      if (run && bus.fetch_req && !f_gnt && (stall_q != STALL_MAX))
        stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign bus.stall_cnt = 16'(stall_q);

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter
//   Directed bench for imem_arbiter. Inputs are driven 1 time unit after the
//   rising edge; combinational grants are sampled 1 unit later, and
//   registered responses just after the following rising edge. The memory
//   array is modelled here with a combinational read and a synchronous write.
//   The stall counter is built 8 bits wide so its saturation point (0x00FF)
//   is reachable in a short run.
module tb_imem_arbiter;

  logic clk;
  logic reset;
  int   nvec = 0;
  int   nmis = 0;
  int   nwrites = 0;

  imem_arbiter_if #(.ADDR_W(8)) bus();

  imem_arbiter #(.ADDR_W(8), .STALL_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      nwrites           <= nwrites + 1;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = 32'h0;
    bus.load_req   = 1'b0;
    bus.load_we    = 1'b0;
    bus.load_addr  = 32'h0;
    bus.load_wdata = 32'h0;
    bus.prog_start = 1'b0;
    bus.prog_done  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h4;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    nvec++; if (bus.cpu_hold !== 1'b1) begin nmis++; $display("FAIL reset_cpu_hold: got %b want 1", bus.cpu_hold); end
    nvec++; if (bus.fetch_gnt !== 1'b0) begin nmis++; $display("FAIL reset_fetch_gnt: got %b want 0", bus.fetch_gnt); end
    nvec++; if (bus.fetch_valid !== 1'b0 || bus.load_valid !== 1'b0) begin nmis++; $display("FAIL reset_valids: got %b%b want 00", bus.fetch_valid, bus.load_valid); end
    nvec++; if (bus.fetch_data !== 32'h0 || bus.load_rdata !== 32'h0) begin nmis++; $display("FAIL reset_data: got %h/%h want 0/0", bus.fetch_data, bus.load_rdata); end
    nvec++; if (bus.stall_cnt !== 16'h0) begin nmis++; $display("FAIL reset_stall_cnt: got %h want 0000", bus.stall_cnt); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_boot_load();
    // fetch_req stays high throughout BOOT and must never be granted.
    bus.load_req = 1'b1; bus.load_we = 1'b1;
    bus.load_addr = 32'h0; bus.load_wdata = 32'h20080005;
    #1;
    nvec++; if (bus.load_gnt !== 1'b1 || bus.fetch_gnt !== 1'b0) begin nmis++; $display("FAIL boot_gnt0: got f=%b l=%b want f=0 l=1", bus.fetch_gnt, bus.load_gnt); end
    nvec++; if (bus.mem_we !== 1'b1 || bus.cpu_hold !== 1'b1) begin nmis++; $display("FAIL boot_we0: got we=%b hold=%b want 1/1", bus.mem_we, bus.cpu_hold); end
    tick();
    nvec++; if (bus.load_valid !== 1'b1 || bus.load_rdata !== 32'h0) begin nmis++; $display("FAIL boot_wack0: got v=%b d=%h want 1/0", bus.load_valid, bus.load_rdata); end
    bus.load_addr = 32'h4; bus.load_wdata = 32'h20090003;
    #1;
    nvec++; if (bus.fetch_gnt !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.mem_addr !== 8'd1) begin nmis++; $display("FAIL boot_wr1: got f=%b hold=%b a=%h want 0/1/01", bus.fetch_gnt, bus.cpu_hold, bus.mem_addr); end
    tick();
    bus.load_we = 1'b0;
    #1;
    tick();
    nvec++; if (bus.load_rdata !== 32'h20090003 || bus.load_err !== 1'b0) begin nmis++; $display("FAIL boot_raw: got %h err=%b want 20090003/0", bus.load_rdata, bus.load_err); end
    bus.load_req = 1'b0; bus.prog_done = 1'b1;
    #1;
    nvec++; if (bus.cpu_hold !== 1'b1 || bus.fetch_gnt !== 1'b0) begin nmis++; $display("FAIL boot_done_cycle: got hold=%b f=%b want 1/0", bus.cpu_hold, bus.fetch_gnt); end
    tick();
    bus.prog_done = 1'b0;
    #1;
    nvec++; if (bus.cpu_hold !== 1'b0 || bus.fetch_gnt !== 1'b1) begin nmis++; $display("FAIL boot_run: got hold=%b f=%b want 0/1", bus.cpu_hold, bus.fetch_gnt); end
    tick();
    nvec++; if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h20090003 || bus.fetch_err !== 1'b0) begin nmis++; $display("FAIL boot_fetch: got v=%b d=%h e=%b want 1/20090003/0", bus.fetch_valid, bus.fetch_data, bus.fetch_err); end
    bus.fetch_req = 1'b0;
    tick();
    nvec++; if (bus.fetch_valid !== 1'b0) begin nmis++; $display("FAIL boot_pulse: got %b want 0", bus.fetch_valid); end
    nvec++; if (bus.stall_cnt !== 16'h0) begin nmis++; $display("FAIL boot_no_stall: got %h want 0000", bus.stall_cnt); end
  endtask

  task automatic test_contention();
    logic exp_f;
    // A lone loader read hands preference back to the fetch side.
    bus.load_req = 1'b1; bus.load_we = 1'b0; bus.load_addr = 32'h0;
    #1;
    tick();
    nvec++; if (bus.load_rdata !== 32'h20080005) begin nmis++; $display("FAIL cont_solo_read: got %h want 20080005", bus.load_rdata); end
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4;
    for (int i = 0; i < 4; i++) begin
      exp_f = (i % 2 == 0);
      #1;
      nvec++; if (bus.fetch_gnt !== exp_f || bus.load_gnt !== !exp_f) begin nmis++; $display("FAIL cont_gnt%0d: got f=%b l=%b want f=%b l=%b", i, bus.fetch_gnt, bus.load_gnt, exp_f, !exp_f); end
      tick();
      nvec++; if (bus.fetch_valid !== exp_f) begin nmis++; $display("FAIL cont_valid%0d: got %b want %b", i, bus.fetch_valid, exp_f); end
    end
    drive_idle();
    nvec++; if (bus.stall_cnt !== 16'd2) begin nmis++; $display("FAIL cont_stall_cnt: got %0d want 2", bus.stall_cnt); end
  endtask

  task automatic test_bad_addr();
    int w0;
    w0 = nwrites;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h2;
    #1;
    nvec++; if (bus.fetch_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin nmis++; $display("FAIL bad_mis_gnt: got g=%b we=%b want 1/0", bus.fetch_gnt, bus.mem_we); end
    tick();
    nvec++; if (bus.fetch_valid !== 1'b1 || bus.fetch_err !== 1'b1 || bus.fetch_data !== 32'h0) begin nmis++; $display("FAIL bad_mis_resp: got v=%b e=%b d=%h want 1/1/0", bus.fetch_valid, bus.fetch_err, bus.fetch_data); end
    bus.fetch_addr = 32'h400;
    #1;
    tick();
    nvec++; if (bus.fetch_valid !== 1'b1 || bus.fetch_err !== 1'b1 || bus.fetch_data !== 32'h0) begin nmis++; $display("FAIL bad_range_resp: got v=%b e=%b d=%h want 1/1/0", bus.fetch_valid, bus.fetch_err, bus.fetch_data); end
    bus.fetch_req = 1'b0;
    bus.load_req = 1'b1; bus.load_we = 1'b1; bus.load_addr = 32'h401; bus.load_wdata = 32'hFFFFFFFF;
    #1;
    nvec++; if (bus.load_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin nmis++; $display("FAIL bad_load_gnt: got g=%b we=%b want 1/0", bus.load_gnt, bus.mem_we); end
    tick();
    nvec++; if (bus.load_err !== 1'b1 || bus.load_valid !== 1'b1) begin nmis++; $display("FAIL bad_load_resp: got v=%b e=%b want 1/1", bus.load_valid, bus.load_err); end
    nvec++; if (nwrites !== w0) begin nmis++; $display("FAIL bad_no_write: got %0d writes want %0d", nwrites, w0); end
    // Highest legal word.
    bus.load_addr = 32'h3FC; bus.load_wdata = 32'hA5A5A5A5;
    #1;
    nvec++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'hFF) begin nmis++; $display("FAIL edge_addr: got we=%b a=%h want 1/ff", bus.mem_we, bus.mem_addr); end
    tick();
    drive_idle();
  endtask

  task automatic test_reload();
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0; bus.prog_start = 1'b1;
    #1;
    nvec++; if (bus.cpu_hold !== 1'b0 || bus.fetch_gnt !== 1'b1) begin nmis++; $display("FAIL rl_start_cycle: got hold=%b f=%b want 0/1", bus.cpu_hold, bus.fetch_gnt); end
    tick();
    bus.prog_start = 1'b0; bus.fetch_addr = 32'h10;
    bus.load_req = 1'b1; bus.load_we = 1'b1; bus.load_addr = 32'h10; bus.load_wdata = 32'hDEADBEEF;
    nvec++; if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 32'h20080005 || bus.cpu_hold !== 1'b1) begin nmis++; $display("FAIL rl_last_fetch: got v=%b d=%h hold=%b want 1/20080005/1", bus.fetch_valid, bus.fetch_data, bus.cpu_hold); end
    #1;
    nvec++; if (bus.fetch_gnt !== 1'b0 || bus.load_gnt !== 1'b1) begin nmis++; $display("FAIL rl_load_gnt: got f=%b l=%b want 0/1", bus.fetch_gnt, bus.load_gnt); end
    tick();
    bus.load_req = 1'b0; bus.prog_start = 1'b1;   // ignored in LOAD
    tick();
    nvec++; if (bus.cpu_hold !== 1'b1) begin nmis++; $display("FAIL rl_start_ignored: got %b want 1", bus.cpu_hold); end
    bus.prog_start = 1'b0; bus.prog_done = 1'b1;
    tick();
    bus.prog_done = 1'b0;
    #1;
    nvec++; if (bus.cpu_hold !== 1'b0 || bus.fetch_gnt !== 1'b1) begin nmis++; $display("FAIL rl_run: got hold=%b f=%b want 0/1", bus.cpu_hold, bus.fetch_gnt); end
    tick();
    nvec++; if (bus.fetch_data !== 32'hDEADBEEF) begin nmis++; $display("FAIL rl_fetch: got %h want deadbeef", bus.fetch_data); end
    bus.fetch_req = 1'b0;
    nvec++; if (bus.stall_cnt !== 16'd2) begin nmis++; $display("FAIL rl_stall_frozen: got %0d want 2", bus.stall_cnt); end
    // Both pulses together outside RUN return to RUN.
    bus.prog_start = 1'b1;
    tick();
    bus.prog_done = 1'b1;
    tick();
    drive_idle();
    nvec++; if (bus.cpu_hold !== 1'b0) begin nmis++; $display("FAIL rl_both_pulses: got %b want 0", bus.cpu_hold); end
  endtask

  task automatic test_saturation_reset();
    int w0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0;
    bus.load_req  = 1'b1; bus.load_we = 1'b0; bus.load_addr = 32'h0;
    repeat (600) tick();
    nvec++; if (bus.stall_cnt !== 16'h00FF) begin nmis++; $display("FAIL sat_reach: got %h want 00ff", bus.stall_cnt); end
    repeat (4) tick();
    nvec++; if (bus.stall_cnt !== 16'h00FF) begin nmis++; $display("FAIL sat_stick: got %h want 00ff", bus.stall_cnt); end
    // Mid-access reset: a response is pending and a write is being granted.
    bus.load_we = 1'b1; bus.load_addr = 32'h20; bus.load_wdata = 32'h12345678;
    w0 = nwrites;
    #2;
    reset = 1'b1;
    #1;
    nvec++; if (bus.cpu_hold !== 1'b1 || bus.fetch_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin nmis++; $display("FAIL rst_async_ctl: got hold=%b f=%b we=%b want 1/0/0", bus.cpu_hold, bus.fetch_gnt, bus.mem_we); end
    nvec++; if (bus.fetch_valid !== 1'b0 || bus.load_valid !== 1'b0 || bus.fetch_err !== 1'b0 || bus.load_err !== 1'b0) begin nmis++; $display("FAIL rst_async_valid: got %b%b%b%b want 0000", bus.fetch_valid, bus.load_valid, bus.fetch_err, bus.load_err); end
    nvec++; if (bus.fetch_data !== 32'h0 || bus.load_rdata !== 32'h0 || bus.stall_cnt !== 16'h0) begin nmis++; $display("FAIL rst_async_data: got %h/%h/%h want 0/0/0", bus.fetch_data, bus.load_rdata, bus.stall_cnt); end
    tick();
    nvec++; if (nwrites !== w0) begin nmis++; $display("FAIL rst_no_write: got %0d writes want %0d", nwrites, w0); end
    drive_idle();
    bus.fetch_req = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
    nvec++; if (bus.cpu_hold !== 1'b1 || bus.fetch_gnt !== 1'b0) begin nmis++; $display("FAIL rst_boot: got hold=%b f=%b want 1/0", bus.cpu_hold, bus.fetch_gnt); end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_boot_load();
    test_contention();
    test_bad_addr();
    test_reload();
    test_saturation_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
